// File: rtl/maint_refresh_handler_pkg.sv
// rtl/maint_refresh_handler_pkg.sv - instruction field offsets, DDR command codes and FSM states
package maint_refresh_handler_pkg;

    // Fixed instruction bit positions shared with the command receiver
    localparam int DDR_INSTR_BIT = 31;
    localparam int CS_OFFSET     = 19;
    localparam int WE_OFFSET     = 21;
    localparam int CAS_OFFSET    = 22;
    localparam int RAS_OFFSET    = 23;

    typedef struct packed {
        logic ras;
        logic cas;
        logic we;
    } ddr_cmd_t;

    localparam ddr_cmd_t CMD_NOP = '{ras: 1'b1, cas: 1'b1, we: 1'b1};
    localparam ddr_cmd_t CMD_PRE = '{ras: 1'b0, cas: 1'b1, we: 1'b0};
    localparam ddr_cmd_t CMD_REF = '{ras: 1'b0, cas: 1'b0, we: 1'b1};
    localparam ddr_cmd_t CMD_ACT = '{ras: 1'b0, cas: 1'b1, we: 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_SCAN,
        ST_PRE,
        ST_TRP_WAIT,
        ST_REF,
        ST_TRFC_WAIT,
        ST_REOPEN,
        ST_DONE
    } mrh_state_t;

endpackage

// File: rtl/maint_refresh_handler_timer.sv
// rtl/maint_refresh_handler_timer.sv - tREFI timer, pending-refresh counter and miss flag
module refresh_timer #(
    parameter int TREFI_CYC = 1560,
    parameter int PEND_MAX  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh_en,
    input  logic       ref_done,
    output logic [3:0] pend_cnt,
    output logic       refresh_miss
);

    localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(TREFI_CYC - 1);
    localparam logic [3:0]           PMAX   = 4'(PEND_MAX);

    logic [CNT_WIDTH-1:0] timer;
    logic                 obligation;

    assign obligation = refresh_en && (timer == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= RELOAD;
        end else if (!refresh_en || obligation) begin
            timer <= RELOAD;
        end else begin
            timer <= timer - CNT_WIDTH'(1);
        end
    end

    // A simultaneous obligation and REF cancel out and never count as a miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt     <= 4'd0;
            refresh_miss <= 1'b0;
        end else if (obligation && !ref_done) begin
            if (pend_cnt == PMAX) begin
                refresh_miss <= 1'b1;
            end else begin
                pend_cnt <= pend_cnt + 4'd1;
            end
        end else if (!obligation && ref_done && pend_cnt != 4'd0) begin
            pend_cnt <= pend_cnt - 4'd1;
        end
    end

endmodule

// File: rtl/maint_refresh_handler.sv
// rtl/maint_refresh_handler.sv - refresh engine: closes open banks, issues REFs, reopens rows
module maint_refresh_handler
    import maint_refresh_handler_pkg::*;
#(
    parameter int ROW_WIDTH  = 16,
    parameter int BANK_WIDTH = 3,
    parameter int CS_WIDTH   = 1,
    parameter int TREFI_CYC  = 1560,
    parameter int TRP_CYC    = 4,
    parameter int TRFC_CYC   = 44,
    parameter int PEND_MAX   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh_en,
    output logic [BANK_WIDTH-1:0] maint_bank,
    input  logic [ROW_WIDTH-1:0]  maint_bank_state,
    output logic                  mnt_req,
    input  logic                  mnt_gnt,
    output logic [31:0]           mnt_instr,
    output logic                  mnt_valid,
    input  logic                  mnt_ready,
    output logic                  busy,
    output logic [3:0]            pend_cnt,
    output logic                  refresh_miss
);

    localparam int                    NUM_BANKS = 1 << BANK_WIDTH;
    localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);
    localparam logic [CNT_WIDTH-1:0]  TRP_LIM   = CNT_WIDTH'(TRP_CYC - 1);
    localparam logic [CNT_WIDTH-1:0]  TRFC_LIM  = CNT_WIDTH'(TRFC_CYC - 1);

    mrh_state_t            state, state_n;
    logic [BANK_WIDTH-1:0] idx, idx_n;
    logic [NUM_BANKS-1:0]  open_mask, open_mask_n;
    logic [CNT_WIDTH-1:0]  gap;
    logic                  xfer, ref_done, last, bank_open;
    ddr_cmd_t              cmd;
    logic [BANK_WIDTH-1:0] cmd_bank;
    logic [ROW_WIDTH-1:0]  cmd_row;

    assign xfer       = mnt_valid && mnt_ready;
    assign ref_done   = xfer && (state == ST_REF);
    assign last       = (idx == LAST_BANK);
    assign bank_open  = maint_bank_state[ROW_WIDTH-1];
    assign maint_bank = idx;
    assign busy       = (state != ST_IDLE);

    refresh_timer #(
        .TREFI_CYC (TREFI_CYC),
        .PEND_MAX  (PEND_MAX),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .refresh_en   (refresh_en),
        .ref_done     (ref_done),
        .pend_cnt     (pend_cnt),
        .refresh_miss (refresh_miss)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            open_mask <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            open_mask <= open_mask_n;
        end
    end

    // gap saturates and restarts on every handshake, so tRP/tRFC are measured from the transfer itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap <= '0;
        end else if (xfer) begin
            gap <= '0;
        end else if (!(&gap)) begin
            gap <= gap + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        open_mask_n = open_mask;
        mnt_req     = 1'b1;
        mnt_valid   = 1'b0;
        cmd         = CMD_NOP;
        cmd_bank    = '0;
        cmd_row     = '0;
        case (state)
            ST_IDLE: begin
                mnt_req = (pend_cnt != 4'd0);
                if (pend_cnt != 4'd0) state_n = ST_REQ;
            end
            ST_REQ: begin
                if (mnt_gnt) begin
                    state_n = ST_SCAN;
                    idx_n   = '0;
                end
            end
            ST_SCAN: begin
                open_mask_n[idx] = bank_open;
                if (bank_open) begin
                    state_n = ST_PRE;
                end else if (last) begin
                    state_n = (|open_mask) ? ST_TRP_WAIT : ST_REF;
                end else begin
                    idx_n = idx + BANK_WIDTH'(1);
                end
            end
            ST_PRE: begin
                mnt_valid = 1'b1;
                cmd       = CMD_PRE;
                cmd_bank  = idx;
                if (xfer) begin
                    if (last) begin
                        state_n = ST_TRP_WAIT;
                    end else begin
                        idx_n   = idx + BANK_WIDTH'(1);
                        state_n = ST_SCAN;
                    end
                end
            end
            ST_TRP_WAIT: begin
                if (gap >= TRP_LIM) state_n = ST_REF;
            end
            ST_REF: begin
                mnt_valid = 1'b1;
                cmd       = CMD_REF;
                if (xfer) state_n = ST_TRFC_WAIT;
            end
            ST_TRFC_WAIT: begin
                if (gap >= TRFC_LIM) begin
                    if (pend_cnt != 4'd0) begin
                        state_n = ST_REF;
                    end else begin
                        idx_n   = '0;
                        state_n = ST_REOPEN;
                    end
                end
            end
            ST_REOPEN: begin
                if (open_mask[idx]) begin
                    mnt_valid = 1'b1;
                    cmd       = CMD_ACT;
                    cmd_bank  = idx;
                    cmd_row   = {1'b0, maint_bank_state[ROW_WIDTH-2:0]};
                end
                if (!open_mask[idx] || xfer) begin
                    if (last) state_n = ST_DONE;
                    else      idx_n   = idx + BANK_WIDTH'(1);
                end
            end
            ST_DONE: begin
                mnt_req     = 1'b0;
                open_mask_n = '0;
                state_n     = ST_IDLE;
            end
            default: begin
                mnt_req = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mnt_instr = '0;
        if (mnt_valid) begin
            mnt_instr[DDR_INSTR_BIT]              = 1'b1;
            mnt_instr[CS_OFFSET +: CS_WIDTH]      = '0;
            mnt_instr[RAS_OFFSET]                 = cmd.ras;
            mnt_instr[CAS_OFFSET]                 = cmd.cas;
            mnt_instr[WE_OFFSET]                  = cmd.we;
            mnt_instr[ROW_WIDTH +: BANK_WIDTH]    = cmd_bank;
            mnt_instr[ROW_WIDTH-1:0]              = cmd_row;
        end
    end

    gnt_held: assert property (@(posedge clk) disable iff (rst)
        (mnt_req && $past(mnt_req) && $past(mnt_gnt)) |-> mnt_gnt);

endmodule

// File: tb/tb_maint_refresh_handler.sv
// tb/tb_maint_refresh_handler.sv - directed checks of the refresh handler
module tb_maint_refresh_handler;

    localparam int TREFI = 100;
    localparam logic [31:0] I_REF  = 32'h8020_0000;
    localparam logic [31:0] I_PRE2 = 32'h8042_0000;
    localparam logic [31:0] I_PRE5 = 32'h8045_0000;
    localparam logic [31:0] I_ACT2 = 32'h8062_0123;
    localparam logic [31:0] I_ACT5 = 32'h8065_7FFF;

    logic        clk = 1'b0, rst = 1'b1, refresh_en = 1'b1, mnt_gnt = 1'b1, mnt_ready = 1'b1;
    logic [2:0]  maint_bank;
    logic [15:0] maint_bank_state;
    logic        mnt_req, mnt_valid, busy, refresh_miss;
    logic [31:0] mnt_instr;
    logic [3:0]  pend_cnt;
    logic [15:0] bank_mem [8];

    int vectors = 0, miscompares = 0, cyc = 0;
    logic [31:0] hs_instr [$];
    int          hs_cyc   [$];

    maint_refresh_handler #(.TREFI_CYC(TREFI)) dut (
        .clk (clk), .rst (rst), .refresh_en (refresh_en),
        .maint_bank (maint_bank), .maint_bank_state (maint_bank_state),
        .mnt_req (mnt_req), .mnt_gnt (mnt_gnt),
        .mnt_instr (mnt_instr), .mnt_valid (mnt_valid), .mnt_ready (mnt_ready),
        .busy (busy), .pend_cnt (pend_cnt), .refresh_miss (refresh_miss)
    );

    assign maint_bank_state = bank_mem[maint_bank];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && mnt_valid && mnt_ready) begin
            hs_instr.push_back(mnt_instr);
            hs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int count_of(input logic [31:0] v);
        int n = 0;
        foreach (hs_instr[i]) if (hs_instr[i] == v) n++;
        return n;
    endfunction

    function automatic logic [31:0] hs_at(input int i);
        return (i < hs_instr.size()) ? hs_instr[i] : 32'h0;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < hs_cyc.size()) ? hs_cyc[i] : 0;
    endfunction

    task automatic clear_hs();
        hs_instr.delete();
        hs_cyc.delete();
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!busy && n < lim) begin @(negedge clk); n++; end
        chk("busy_rise", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < lim) begin @(negedge clk); n++; end
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!mnt_req && n < 4 * TREFI) begin @(negedge clk); n++; end
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] held;
        foreach (bank_mem[i]) bank_mem[i] = 16'h0000;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_req",   {31'd0, mnt_req},   32'd0);
        chk("rst_valid", {31'd0, mnt_valid}, 32'd0);
        chk("rst_instr", mnt_instr,          32'd0);
        chk("rst_bank",  {29'd0, maint_bank}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_pend",  {28'd0, pend_cnt},  32'd0);
        chk("rst_miss",  {31'd0, refresh_miss}, 32'd0);

        // all banks closed: single REF
        rst = 1'b0;
        wait_req(n);
        chk("t1_req_latency", n, TREFI);
        wait_idle(400);
        chk("t1_hs_count", hs_instr.size(), 1);
        chk("t1_ref_instr", hs_at(0), I_REF);
        chk("t1_pend", {28'd0, pend_cnt}, 32'd0);

        // banks 2 and 5 open
        bank_mem[2] = 16'h8123;
        bank_mem[5] = 16'hFFFF;
        clear_hs();
        wait_idle(400);
        chk("t2_hs_count", hs_instr.size(), 5);
        chk("t2_pre2", hs_at(0), I_PRE2);
        chk("t2_pre5", hs_at(1), I_PRE5);
        chk("t2_ref",  hs_at(2), I_REF);
        chk("t2_act2", hs_at(3), I_ACT2);
        chk("t2_act5", hs_at(4), I_ACT5);
        chk("t2_trp",   {31'd0, (cyc_at(2) - cyc_at(1)) >= 4},  32'd1);
        chk("t2_trfc2", {31'd0, (cyc_at(3) - cyc_at(2)) >= 44}, 32'd1);
        chk("t2_trfc5", {31'd0, (cyc_at(4) - cyc_at(2)) >= 44}, 32'd1);

        // back-pressure during PRE
        clear_hs();
        mnt_ready = 1'b0;
        n = 0;
        while (!mnt_valid && n < 300) begin @(negedge clk); n++; end
        held = mnt_instr;
        chk("t3_first_instr", held, I_PRE2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_valid_held", {31'd0, mnt_valid}, 32'd1);
            chk("t3_instr_held", mnt_instr, held);
        end
        mnt_ready = 1'b1;
        wait_idle(400);
        chk("t3_pre2_once", count_of(I_PRE2), 1);
        chk("t3_hs_count", hs_instr.size(), 5);

        // grant withheld for 9 obligations
        mnt_gnt = 1'b0;
        repeat (9 * TREFI) @(negedge clk);
        chk("t4_pend_sat", {28'd0, pend_cnt}, 32'd8);
        chk("t4_miss", {31'd0, refresh_miss}, 32'd1);
        clear_hs();
        refresh_en = 1'b0;
        mnt_gnt = 1'b1;
        wait_idle(1000);
        chk("t4_hs_count", hs_instr.size(), 12);
        chk("t4_ref_count", count_of(I_REF), 8);
        chk("t4_act2_count", count_of(I_ACT2), 1);
        chk("t4_act5_count", count_of(I_ACT5), 1);
        for (int i = 3; i < 10; i++)
            chk("t4_ref_gap", {31'd0, (cyc_at(i) - cyc_at(i - 1)) >= 44}, 32'd1);
        chk("t4_act_after", hs_at(10), I_ACT2);
        chk("t4_pend_end", {28'd0, pend_cnt}, 32'd0);
        chk("t4_miss_sticky", {31'd0, refresh_miss}, 32'd1);

        // reset during TRFC_WAIT
        clear_hs();
        refresh_en = 1'b1;
        n = 0;
        while (count_of(I_REF) == 0 && n < 300) begin @(negedge clk); n++; end
        chk("t5_ref_seen", count_of(I_REF), 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_req",   {31'd0, mnt_req},   32'd0);
        chk("t5_valid", {31'd0, mnt_valid}, 32'd0);
        chk("t5_instr", mnt_instr,          32'd0);
        chk("t5_busy",  {31'd0, busy},      32'd0);
        chk("t5_pend",  {28'd0, pend_cnt},  32'd0);
        chk("t5_miss",  {31'd0, refresh_miss}, 32'd0);
        chk("t5_bank",  {29'd0, maint_bank}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_hs();
        wait_req(n);
        chk("t5_req_latency", n, TREFI);
        wait_idle(400);
        chk("t5_ref_count", count_of(I_REF), 1);
        chk("t5_hs_count", hs_instr.size(), 5);

        // timer disabled
        refresh_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 5 * TREFI; i++) begin
            @(negedge clk);
            if (mnt_req || pend_cnt != 4'd0) seen++;
        end
        chk("t6_no_activity", seen, 0);
        refresh_en = 1'b1;
        wait_req(n);
        chk("t6_req_latency", n, TREFI);
        wait_idle(400);
        chk("t6_pend_end", {28'd0, pend_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
